// File: rtl/nor7_zero_debounce_if.sv
// rtl/nor7_zero_debounce_if.sv - control, operand and result bundle for the nor7 zero-detect debouncer
//
// Signals:
//   sp            capture/filter/counter enable
//   clr           synchronous clear of evt and ovf
//   a0..a6        operand bits feeding the NOR
//   zn0           filtered all-zero flag (1 = all operands zero)
//   rise0, fall0  one-cycle edge pulses of zn0
//   evt           saturating count of zn0 rising edges
//   ovf           sticky flag, a rise was seen while evt was all-ones
// Modports: master drives sp/clr/a*, slave (the debouncer) drives the results.

interface nor7_zero_debounce_if #(
    parameter int CNT_W = 8
);
    logic             sp;
    logic             clr;
    logic             a0;
    logic             a1;
    logic             a2;
    logic             a3;
    logic             a4;
    logic             a5;
    logic             a6;
    logic             zn0;
    logic             rise0;
    logic             fall0;
    logic [CNT_W-1:0] evt;
    logic             ovf;

    modport master (
        output sp, clr, a0, a1, a2, a3, a4, a5, a6,
        input  zn0, rise0, fall0, evt, ovf
    );

    modport slave (
        input  sp, clr, a0, a1, a2, a3, a4, a5, a6,
        output zn0, rise0, fall0, evt, ovf
    );
endinterface

// File: rtl/nor7_zero_debounce.sv
// rtl/nor7_zero_debounce.sv - registered all-zero detect of seven bits with glitch filter, edge pulses and event counter
//
// Captures a0..a6 when sp=1, forms their NOR (raw), and only lets zn0 follow
// raw after raw has disagreed with zn0 for FILT_LEN consecutive enabled
// cycles. Disabled cycles (sp=0) freeze the qualification run.
//
// Ports:
//   ck    clock, rising edge
//   cd    asynchronous active-high reset, clears all state (zn0 resets to 1)
//   bus   nor7_zero_debounce_if slave: sp, clr, a0..a6 in; zn0, rise0,
//         fall0, evt[CNT_W-1:0], ovf out
//
// Parameters:
//   FILT_LEN  1..255, enabled cycles of disagreement needed to flip zn0
//   CNT_W     1..16, width of the saturating rise counter evt

module nor7_zero_debounce #(
    parameter int FILT_LEN = 4,
    parameter int CNT_W    = 8
) (
    input  logic                   ck,
    input  logic                   cd,
    nor7_zero_debounce_if.slave    bus
);

    typedef enum logic [1:0] {
        S_ONE  = 2'd0,
        S_Q0   = 2'd1,
        S_ZERO = 2'd2,
        S_Q1   = 2'd3
    } state_t;

    localparam logic [8:0]       FILT     = 9'(FILT_LEN);
    localparam bit               FILT_ONE = (FILT_LEN == 1);
    localparam logic [CNT_W-1:0] EVT_MAX  = '1;
    localparam logic [CNT_W-1:0] EVT_ONE  = CNT_W'(1);

    logic [6:0]       cap;
    logic             raw;
    state_t           state;
    state_t           state_nxt;
    logic [7:0]       q;
    logic [7:0]       q_nxt;
    logic             q_done;
    logic             zn0_q;
    logic             zn0_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic             rise_q;
    logic             fall_q;
    logic [CNT_W-1:0] evt_q;
    logic             ovf_q;

    // Capture register; reset to zero so raw comes out of reset as 1.
    always_ff @(posedge ck or posedge cd) begin
        if (cd) begin
            cap <= 7'd0;
        end else if (bus.sp) begin
            cap <= {bus.a6, bus.a5, bus.a4, bus.a3, bus.a2, bus.a1, bus.a0};
        end
    end

    assign raw = ~|cap;

    // This cycle would be the FILT_LEN-th consecutive disagreement.
    assign q_done = ({1'b0, q} + 9'd1) == FILT;

    always_ff @(posedge ck or posedge cd) begin
        if (cd) begin
            state <= S_ONE;
            q     <= 8'd0;
            zn0_q <= 1'b1;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            zn0_q <= zn0_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        if (bus.sp) begin
            case (state)
                S_ONE: begin
                    if (!raw) begin
                        if (FILT_ONE) begin
                            state_nxt = S_ZERO;
                        end else begin
                            q_nxt     = 8'd1;
                            state_nxt = S_Q0;
                        end
                    end
                end
                S_Q0: begin
                    if (!raw) begin
                        if (q_done) begin
                            state_nxt = S_ZERO;
                            q_nxt     = 8'd0;
                        end else begin
                            q_nxt = q + 8'd1;
                        end
                    end else begin
                        state_nxt = S_ONE;
                        q_nxt     = 8'd0;
                    end
                end
                S_ZERO: begin
                    if (raw) begin
                        if (FILT_ONE) begin
                            state_nxt = S_ONE;
                        end else begin
                            q_nxt     = 8'd1;
                            state_nxt = S_Q1;
                        end
                    end
                end
                S_Q1: begin
                    if (raw) begin
                        if (q_done) begin
                            state_nxt = S_ONE;
                            q_nxt     = 8'd0;
                        end else begin
                            q_nxt = q + 8'd1;
                        end
                    end else begin
                        state_nxt = S_ZERO;
                        q_nxt     = 8'd0;
                    end
                end
                default: begin
                    state_nxt = S_ONE;
                    q_nxt     = 8'd0;
                end
            endcase
        end
        // zn0 stays at its old value while a change is still qualifying.
        zn0_nxt  = (state_nxt == S_ONE) || (state_nxt == S_Q0);
        rise_nxt = zn0_nxt & ~zn0_q;
        fall_nxt = ~zn0_nxt & zn0_q;
    end

    // Pulses are recomputed every edge, so they drop after one cycle even with sp=0.
    always_ff @(posedge ck or posedge cd) begin
        if (cd) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            evt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            rise_q <= rise_nxt;
            fall_q <= fall_nxt;
            if (bus.clr) begin
                evt_q <= '0;
                ovf_q <= 1'b0;
            end else if (rise_nxt) begin
                if (evt_q == EVT_MAX) begin
                    ovf_q <= 1'b1;
                end else begin
                    evt_q <= evt_q + EVT_ONE;
                end
            end
        end
    end

    assign bus.zn0   = zn0_q;
    assign bus.rise0 = rise_q;
    assign bus.fall0 = fall_q;
    assign bus.evt   = evt_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_nor7_zero_debounce.sv
// tb/tb_nor7_zero_debounce.sv - self-checking bench for nor7_zero_debounce across three parameter sets

module tb_nor7_zero_debounce;

    logic       ck = 1'b0;
    logic       cd;
    logic       sp;
    logic       clr;
    logic [6:0] a;

    int errors = 0;
    int checks = 0;

    always #5 ck = ~ck;

    // u0: FILT_LEN=4 CNT_W=8, u1: FILT_LEN=4 CNT_W=2, u2: FILT_LEN=1 CNT_W=8
    nor7_zero_debounce_if #(.CNT_W(8)) i0 ();
    nor7_zero_debounce_if #(.CNT_W(2)) i1 ();
    nor7_zero_debounce_if #(.CNT_W(8)) i2 ();

    assign i0.sp = sp;
    assign i1.sp = sp;
    assign i2.sp = sp;
    assign i0.clr = clr;
    assign i1.clr = clr;
    assign i2.clr = clr;
    assign {i0.a6, i0.a5, i0.a4, i0.a3, i0.a2, i0.a1, i0.a0} = a;
    assign {i1.a6, i1.a5, i1.a4, i1.a3, i1.a2, i1.a1, i1.a0} = a;
    assign {i2.a6, i2.a5, i2.a4, i2.a3, i2.a2, i2.a1, i2.a0} = a;

    nor7_zero_debounce #(.FILT_LEN(4), .CNT_W(8)) u0 (.ck(ck), .cd(cd), .bus(i0.slave));
    nor7_zero_debounce #(.FILT_LEN(4), .CNT_W(2)) u1 (.ck(ck), .cd(cd), .bus(i1.slave));
    nor7_zero_debounce #(.FILT_LEN(1), .CNT_W(8)) u2 (.ck(ck), .cd(cd), .bus(i2.slave));

    logic d_zn[3];
    logic d_rise[3];
    logic d_fall[3];
    logic d_ovf[3];
    int   d_evt[3];

    assign d_zn[0] = i0.zn0;
    assign d_zn[1] = i1.zn0;
    assign d_zn[2] = i2.zn0;
    assign d_rise[0] = i0.rise0;
    assign d_rise[1] = i1.rise0;
    assign d_rise[2] = i2.rise0;
    assign d_fall[0] = i0.fall0;
    assign d_fall[1] = i1.fall0;
    assign d_fall[2] = i2.fall0;
    assign d_ovf[0] = i0.ovf;
    assign d_ovf[1] = i1.ovf;
    assign d_ovf[2] = i2.ovf;
    assign d_evt[0] = int'(i0.evt);
    assign d_evt[1] = int'(i1.evt);
    assign d_evt[2] = int'(i2.evt);

    // Reference model: zn0 flips once raw has disagreed with it for
    // filt[i] consecutive enabled cycles; evt counts rises up to emax[i].
    int         filt[3] = '{4, 4, 1};
    int         emax[3] = '{255, 3, 255};
    logic [6:0] m_cap;
    bit         m_zn[3];
    int         m_run[3];
    bit         m_rise[3];
    bit         m_fall[3];
    int         m_evt[3];
    bit         m_ovf[3];

    task automatic model_reset();
        m_cap = 7'd0;
        for (int i = 0; i < 3; i++) begin
            m_zn[i]   = 1'b1;
            m_run[i]  = 0;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            m_evt[i]  = 0;
            m_ovf[i]  = 1'b0;
        end
    endtask

    task automatic model_step();
        bit raw_now;
        bit old_zn;
        if (cd) begin
            model_reset();
            return;
        end
        raw_now = (m_cap == 7'd0);
        for (int i = 0; i < 3; i++) begin
            old_zn = m_zn[i];
            if (sp) begin
                if (raw_now != m_zn[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= filt[i]) begin
                        m_zn[i]  = raw_now;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_rise[i] = !old_zn && m_zn[i];
            m_fall[i] = old_zn && !m_zn[i];
            if (clr) begin
                m_evt[i] = 0;
                m_ovf[i] = 1'b0;
            end else if (m_rise[i]) begin
                if (m_evt[i] == emax[i]) m_ovf[i] = 1'b1;
                else m_evt[i]++;
            end
        end
        if (sp) m_cap = a;
    endtask

    task automatic chk(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s u%0d at %0t: got %0d expected %0d", name, inst, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk("zn0", i, int'(d_zn[i]), int'(m_zn[i]));
            chk("rise0", i, int'(d_rise[i]), int'(m_rise[i]));
            chk("fall0", i, int'(d_fall[i]), int'(m_fall[i]));
            chk("evt", i, d_evt[i], m_evt[i]);
            chk("ovf", i, int'(d_ovf[i]), int'(m_ovf[i]));
        end
    endtask

    task automatic cycle();
        @(posedge ck);
        model_step();
        #1;
        compare_all();
    endtask

    // Called 1 time unit after a rising edge; the pulse ends before the next edge.
    task automatic pulse_reset();
        #2 cd = 1'b1;
        model_reset();
        #1 compare_all();
        #2 cd = 1'b0;
    endtask

    typedef struct {
        logic [6:0] a;
        bit         zn0;
        bit         rise0;
        bit         fall0;
        int         evt;
    } vec_t;

    function automatic vec_t mk(input logic [6:0] va, input bit z, input bit r, input bit f, input int e);
        vec_t v;
        v.a = va; v.zn0 = z; v.rise0 = r; v.fall0 = f; v.evt = e;
        return v;
    endfunction

    vec_t tbl[20];

    initial begin
        bit exp_zn;

        // Expected u0 (FILT_LEN=4) response per edge; A3 captured at row 1,
        // A5 glitch of three enabled cycles at rows 13..15.
        tbl[0]  = mk(7'h00, 1, 0, 0, 0);
        tbl[1]  = mk(7'h08, 1, 0, 0, 0);
        tbl[2]  = mk(7'h08, 1, 0, 0, 0);
        tbl[3]  = mk(7'h08, 1, 0, 0, 0);
        tbl[4]  = mk(7'h08, 1, 0, 0, 0);
        tbl[5]  = mk(7'h08, 0, 0, 1, 0);
        tbl[6]  = mk(7'h08, 0, 0, 0, 0);
        tbl[7]  = mk(7'h00, 0, 0, 0, 0);
        tbl[8]  = mk(7'h00, 0, 0, 0, 0);
        tbl[9]  = mk(7'h00, 0, 0, 0, 0);
        tbl[10] = mk(7'h00, 0, 0, 0, 0);
        tbl[11] = mk(7'h00, 1, 1, 0, 1);
        tbl[12] = mk(7'h00, 1, 0, 0, 1);
        tbl[13] = mk(7'h20, 1, 0, 0, 1);
        tbl[14] = mk(7'h20, 1, 0, 0, 1);
        tbl[15] = mk(7'h20, 1, 0, 0, 1);
        tbl[16] = mk(7'h00, 1, 0, 0, 1);
        tbl[17] = mk(7'h00, 1, 0, 0, 1);
        tbl[18] = mk(7'h00, 1, 0, 0, 1);
        tbl[19] = mk(7'h00, 1, 0, 0, 1);

        cd  = 1'b1;
        sp  = 1'b0;
        clr = 1'b0;
        a   = 7'd0;
        model_reset();
        #7 compare_all();
        @(posedge ck);
        #1 cd = 1'b0;
        sp = 1'b1;

        // Table-driven debounce and glitch rejection
        for (int r = 0; r < 20; r++) begin
            a = tbl[r].a;
            cycle();
            chk("tbl_zn0", 0, int'(d_zn[0]), int'(tbl[r].zn0));
            chk("tbl_rise0", 0, int'(d_rise[0]), int'(tbl[r].rise0));
            chk("tbl_fall0", 0, int'(d_fall[0]), int'(tbl[r].fall0));
            chk("tbl_evt", 0, d_evt[0], tbl[r].evt);
        end

        // Reset in the middle of qualification (u0 at q=2)
        a = 7'h08;
        repeat (3) cycle();
        pulse_reset();
        chk("rst_zn0", 0, int'(d_zn[0]), 1);
        chk("rst_evt", 0, d_evt[0], 0);
        chk("rst_ovf", 0, int'(d_ovf[0]), 0);
        a = 7'h00;
        repeat (6) begin
            cycle();
            chk("hold_zn0", 0, int'(d_zn[0]), 1);
            chk("hold_rise0", 0, int'(d_rise[0]), 0);
            chk("hold_fall0", 0, int'(d_fall[0]), 0);
        end

        // Enable gating: capture at e, sp low for e+2..e+4, u0 falls at e+7
        a = 7'h01;
        cycle();
        cycle();
        sp = 1'b0;
        repeat (3) cycle();
        sp = 1'b1;
        cycle();
        cycle();
        chk("gate_zn0_early", 0, int'(d_zn[0]), 1);
        cycle();
        chk("gate_zn0", 0, int'(d_zn[0]), 0);
        chk("gate_fall0", 0, int'(d_fall[0]), 1);
        cycle();
        chk("gate_fall0_end", 0, int'(d_fall[0]), 0);
        a = 7'h00;
        repeat (6) cycle();

        // Saturation on u1 (CNT_W=2)
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            a = 7'h08;
            repeat (6) cycle();
            a = 7'h00;
            repeat (4) cycle();
            cycle();
            chk("sat_rise0", 1, int'(d_rise[1]), 1);
            chk("sat_evt", 1, d_evt[1], (k + 1 > 3) ? 3 : k + 1);
            chk("sat_ovf", 1, int'(d_ovf[1]), (k >= 3) ? 1 : 0);
        end
        a = 7'h08;
        repeat (6) cycle();
        a = 7'h00;
        repeat (4) cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("clr_rise0", 1, int'(d_rise[1]), 1);
        chk("clr_evt", 1, d_evt[1], 0);
        chk("clr_ovf", 1, int'(d_ovf[1]), 0);
        repeat (2) cycle();

        // FILT_LEN=1 (u2) follows raw one edge after capture
        a = 7'h00;
        repeat (2) cycle();
        for (int k = 0; k < 8; k++) begin
            a = (k % 2 == 0) ? 7'h01 : 7'h00;
            cycle();
            if (k > 0) begin
                exp_zn = (k % 2 == 0);
                chk("f1_zn0", 2, int'(d_zn[2]), int'(exp_zn));
                chk("f1_rise0", 2, int'(d_rise[2]), int'(exp_zn));
                chk("f1_fall0", 2, int'(d_fall[2]), int'(!exp_zn));
            end
        end
        a = 7'h00;
        repeat (6) cycle();

        // Randomized run against the model
        repeat (3000) begin
            sp  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 5) == 0)
                a = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'h00;
            if ($urandom_range(0, 499) == 0)
                pulse_reset();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
